// File: rtl/pc_block_pkg.sv
// Shared PC-select codes and datapath constants for the PC block and the control unit.
package pc_block_pkg;

    localparam int              WIDTH    = 16;
    localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;

    localparam logic [3:0] PCSRC_INC      = 4'd0;
    localparam logic [3:0] PCSRC_IMM_PC   = 4'd1;
    localparam logic [3:0] PCSRC_IMM_ADDR = 4'd2;
    localparam logic [3:0] PCSRC_RA       = 4'd3;
    localparam logic [3:0] PCSRC_MARY     = 4'd4;
    localparam logic [3:0] PCSRC_PC_MARY  = 4'd5;
    localparam logic [3:0] PCSRC_JCMP     = 4'd6;
    localparam logic [3:0] PCSRC_JCMP_LS  = 4'd7;

endpackage

// File: rtl/pc_block_pc_src_mux.sv
// Combinational next-PC source select; reserved codes fall back to sequential fetch.
module pc_src_mux
    import pc_block_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [3:0]   sel_i,
    input  logic [W-1:0] pc_inc_i,
    input  logic [W-1:0] imm_plus_pc_i,
    input  logic [W-1:0] imm_addr_i,
    input  logic [W-1:0] ra_i,
    input  logic [W-1:0] mary_i,
    input  logic [W-1:0] pc_plus_mary_i,
    input  logic [W-1:0] jcmp_imm_i,
    input  logic [W-1:0] jcmp_imm_ls_i,
    output logic [W-1:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_inc_i;
        case (sel_i)
            PCSRC_IMM_PC:   next_pc_o = imm_plus_pc_i;
            PCSRC_IMM_ADDR: next_pc_o = imm_addr_i;
            PCSRC_RA:       next_pc_o = ra_i;
            PCSRC_MARY:     next_pc_o = mary_i;
            PCSRC_PC_MARY:  next_pc_o = pc_plus_mary_i;
            PCSRC_JCMP:     next_pc_o = jcmp_imm_i;
            PCSRC_JCMP_LS:  next_pc_o = jcmp_imm_ls_i;
            default:        next_pc_o = pc_inc_i;
        endcase
    end

endmodule

// File: rtl/pc_block.sv
// Program counter: holds the PC, builds PC+INC and loads the selected source when pcWrite is high.
// Define PC_BLOCK_ALIGN_EN to clear bit 0 on load and flag odd targets on pcMisaligned.
module pc_block #(
    parameter int                            WIDTH    = pc_block_pkg::WIDTH,
    parameter int                            INC      = 2,
    parameter logic [pc_block_pkg::WIDTH-1:0] RESET_PC = pc_block_pkg::RESET_PC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       pcSrc,
    input  logic [WIDTH-1:0] immPlusPC,
    input  logic [WIDTH-1:0] immAddr,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] mary,
    input  logic [WIDTH-1:0] pcPlusMary,
    input  logic [WIDTH-1:0] jcmpImm,
    input  logic [WIDTH-1:0] jcmpImmLS,
    input  logic             pcWrite,
`ifdef PC_BLOCK_ALIGN_EN
    output logic             pcMisaligned,
`endif
    output logic [WIDTH-1:0] pcCur
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] sel_pc;

    // Natural truncation gives the modulo-2^WIDTH wrap.
    assign pc_inc = pc_q + WIDTH'(INC);

    pc_src_mux #(.W(WIDTH)) u_src_mux (
        .sel_i          (pcSrc),
        .pc_inc_i       (pc_inc),
        .imm_plus_pc_i  (immPlusPC),
        .imm_addr_i     (immAddr),
        .ra_i           (ra),
        .mary_i         (mary),
        .pc_plus_mary_i (pcPlusMary),
        .jcmp_imm_i     (jcmpImm),
        .jcmp_imm_ls_i  (jcmpImmLS),
        .next_pc_o      (sel_pc)
    );

`ifdef PC_BLOCK_ALIGN_EN
    logic misaligned_q;

    assign pc_d = {sel_pc[WIDTH-1:1], 1'b0};

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            misaligned_q <= 1'b0;
        else if (pcWrite)
            misaligned_q <= sel_pc[0];
    end

    assign pcMisaligned = misaligned_q;
`else
    assign pc_d = sel_pc;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pc_q <= RESET_PC[WIDTH-1:0];
        else if (pcWrite)
            pc_q <= pc_d;
    end

    assign pcCur = pc_q;

endmodule

// File: tb/tb_pc_block.sv
// Directed-vector bench for pc_block; define PC_BLOCK_ALIGN_EN to also exercise alignment.
module tb_pc_block;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  pcSrc = 4'd0;
    logic [15:0] immPlusPC = 16'h0, immAddr = 16'h0, ra = 16'h0, mary = 16'h0;
    logic [15:0] pcPlusMary = 16'h0, jcmpImm = 16'h0, jcmpImmLS = 16'h0;
    logic        pcWrite = 1'b0;
    logic [15:0] pcCur;
`ifdef PC_BLOCK_ALIGN_EN
    logic        pcMisaligned;
`endif

    int checks = 0;
    int errors = 0;

    pc_block dut (
        .clock      (clock),
        .reset      (reset),
        .pcSrc      (pcSrc),
        .immPlusPC  (immPlusPC),
        .immAddr    (immAddr),
        .ra         (ra),
        .mary       (mary),
        .pcPlusMary (pcPlusMary),
        .jcmpImm    (jcmpImm),
        .jcmpImmLS  (jcmpImmLS),
        .pcWrite    (pcWrite),
`ifdef PC_BLOCK_ALIGN_EN
        .pcMisaligned (pcMisaligned),
`endif
        .pcCur      (pcCur)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset applied between edges with a pending absolute load.
        pcWrite = 1'b1; pcSrc = 4'd2; immAddr = 16'd42;
        #2 reset = 1'b1;
        #1 chk("reset_async", pcCur, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold", pcCur, 16'h0000);
        end
`ifdef PC_BLOCK_ALIGN_EN
        chk("reset_misaligned", {15'd0, pcMisaligned}, 16'h0000);
`endif

        // Hold with pcWrite low.
        reset = 1'b0; pcWrite = 1'b0; pcSrc = 4'd2; immAddr = 16'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold", pcCur, 16'h0000);
        end
        immAddr = 16'd42;
        tick();
        chk("hold_new_input", pcCur, 16'h0000);

        // Absolute load then sequential increments.
        pcWrite = 1'b1;
        tick();
        chk("abs_load", pcCur, 16'd42);
        pcSrc = 4'd0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("increment", pcCur, 16'(42 + 2 * i));
        end

        // Source sweep.
        pcSrc = 4'd2; immAddr = 16'd100;
        tick();
        chk("load_100", pcCur, 16'd100);
        immPlusPC = 16'h1000; immAddr = 16'h2000; ra = 16'h3000; mary = 16'h4000;
        pcPlusMary = 16'h5000; jcmpImm = 16'h6000; jcmpImmLS = 16'h7000;
        for (int n = 1; n <= 7; n++) begin
            pcSrc = 4'(n);
            tick();
            chk($sformatf("src_%0d", n), pcCur, 16'(16'h1000 * n));
        end
        pcSrc = 4'd9;
        tick();
        chk("src_reserved_9", pcCur, 16'h7002);
        pcSrc = 4'd15;
        tick();
        chk("src_reserved_15", pcCur, 16'h7004);

        // Unknown select with pcWrite low must not disturb the PC.
        pcWrite = 1'b0; pcSrc = 4'bxxxx;
        tick();
        chk("x_sel_hold", pcCur, 16'h7004);

        // Wrap.
        pcWrite = 1'b1; pcSrc = 4'd2; immAddr = 16'hFFFE;
        tick();
        chk("load_fffe", pcCur, 16'hFFFE);
        pcSrc = 4'd0;
        tick();
        chk("wrap", pcCur, 16'h0000);
        tick();
        chk("after_wrap", pcCur, 16'h0002);

        // Mid-run reset pulse between edges.
        #3 reset = 1'b1;
        #1 chk("mid_reset", pcCur, 16'h0000);
        reset = 1'b0;
        tick();
        chk("resume_1", pcCur, 16'h0002);
        tick();
        chk("resume_2", pcCur, 16'h0004);

        // Odd target handling.
        pcSrc = 4'd2; immAddr = 16'd43;
        tick();
`ifdef PC_BLOCK_ALIGN_EN
        chk("align_pc", pcCur, 16'd42);
        chk("align_flag_set", {15'd0, pcMisaligned}, 16'h0001);
        immAddr = 16'd44;
        tick();
        chk("align_pc_even", pcCur, 16'd44);
        chk("align_flag_clr", {15'd0, pcMisaligned}, 16'h0000);
`else
        chk("odd_unmodified", pcCur, 16'd43);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
